// File: rtl/at_cmd_sequencer.sv
// at_cmd_sequencer: walks a table of AT commands, emitting each byte by byte followed by CR/LF,
// paced by a byte gap, the transmitter-ready handshake and an inter-command gap.
module at_cmd_sequencer #(
   parameter int NUM_CMDS = 3,
   parameter int MAX_LEN = 8,
   parameter logic [NUM_CMDS*MAX_LEN*8-1:0] CMD_TABLE = {
      64'h5452_4145_482B_5441,
      64'h0032_4F50_532B_5441,
      64'h0000_0000_542B_5441
   },
   parameter int BYTE_GAP_CYC = 100_000,
   parameter int CMD_GAP_CYC = 50_000_000,
   parameter bit LOOP = 1'b0,
   localparam int CW = NUM_CMDS > 1 ? $clog2(NUM_CMDS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic          tx_ready,
   output logic [7:0]    data,
   output logic          send_en,
   output logic          busy,
   output logic [CW-1:0] cmd_idx,
   output logic          done
);
   localparam int BW = $clog2(MAX_LEN + 1);
   localparam int GMAX = BYTE_GAP_CYC > CMD_GAP_CYC ? BYTE_GAP_CYC : CMD_GAP_CYC;
   localparam int NW = $clog2(GMAX + 1);
   localparam logic [NW-1:0] BYTE_RELOAD = NW'(BYTE_GAP_CYC - 1);
   localparam logic [NW-1:0] CMD_RELOAD = NW'(CMD_GAP_CYC - 1);
   localparam logic [CW-1:0] LAST_CMD = CW'(NUM_CMDS - 1);
   localparam logic [BW-1:0] END_IDX = BW'(MAX_LEN);

   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_BYTE, CMD_GAP} state_t;
   typedef enum logic [1:0] {PH_PAYLOAD, PH_CR, PH_LF} phase_t;

   state_t        state_q, state_d;
   phase_t        phase_q, phase_d;
   logic [BW-1:0] byte_idx_q, byte_idx_d;
   logic [CW-1:0] cmd_idx_q, cmd_idx_d;
   logic [NW-1:0] cnt_q, cnt_d;
   logic [7:0]    data_q, data_d;
   logic          send_en_q, send_en_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [7:0]    tbl_byte;

   always_comb begin
      tbl_byte = 8'h00;
      for (int i = 0; i < NUM_CMDS; i++)
         for (int j = 0; j < MAX_LEN; j++)
            if (cmd_idx_q == CW'(i) && byte_idx_q == BW'(j))
               tbl_byte = CMD_TABLE[(i*MAX_LEN + j)*8 +: 8];
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      byte_idx_d = byte_idx_q;
      cmd_idx_d  = cmd_idx_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      send_en_d  = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         IDLE:
            if (start) begin
               state_d    = FETCH;
               cmd_idx_d  = '0;
               byte_idx_d = '0;
               phase_d    = PH_PAYLOAD;
            end
         FETCH: begin
            state_d = ISSUE;
            // a zero byte or a full slot ends the payload early
            if (phase_q == PH_PAYLOAD && byte_idx_q != END_IDX && tbl_byte != 8'h00)
               data_d = tbl_byte;
            else if (phase_q == PH_LF)
               data_d = 8'h0A;
            else begin
               data_d  = 8'h0D;
               phase_d = PH_CR;
            end
         end
         ISSUE:
            if (tx_ready) begin
               send_en_d = 1'b1;
               cnt_d     = BYTE_RELOAD;
               state_d   = WAIT_BYTE;
            end
         WAIT_BYTE:
            if (cnt_q != '0)
               cnt_d = cnt_q - 1'b1;
            else if (phase_q == PH_LF) begin
               cnt_d   = CMD_RELOAD;
               state_d = CMD_GAP;
            end else begin
               state_d = FETCH;
               if (phase_q == PH_CR)
                  phase_d = PH_LF;
               else
                  byte_idx_d = byte_idx_q + 1'b1;
            end
         CMD_GAP:
            if (cnt_q != '0)
               cnt_d = cnt_q - 1'b1;
            else if (cmd_idx_q != LAST_CMD || LOOP) begin
               state_d    = FETCH;
               cmd_idx_d  = cmd_idx_q == LAST_CMD ? '0 : cmd_idx_q + 1'b1;
               byte_idx_d = '0;
               phase_d    = PH_PAYLOAD;
            end else begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         default: state_d = IDLE;
      endcase
      if (stop) begin
         state_d    = IDLE;
         send_en_d  = 1'b0;
         done_d     = 1'b0;
         cmd_idx_d  = '0;
         byte_idx_d = '0;
         cnt_d      = '0;
         phase_d    = PH_PAYLOAD;
      end
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         phase_q    <= PH_PAYLOAD;
         byte_idx_q <= '0;
         cmd_idx_q  <= '0;
         cnt_q      <= '0;
         data_q     <= 8'h00;
         send_en_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         byte_idx_q <= byte_idx_d;
         cmd_idx_q  <= cmd_idx_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         send_en_q  <= send_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign data    = data_q;
   assign send_en = send_en_q;
   assign busy    = busy_q;
   assign cmd_idx = cmd_idx_q;
   assign done    = done_q;
endmodule

// File: tb/tb_at_cmd_sequencer.sv
// tb_at_cmd_sequencer: table-driven runs plus hand-written corner sequences, checked by a pulse scoreboard.
`timescale 1ns/1ps
module tb_at_cmd_sequencer;
   localparam int G = 4, C = 20, SHORT = G + 2, LONG = G + C + 2;
   localparam string FULL = "AT+T|~AT+SPO2|~AT+HEART|~";

   typedef struct {
      int         sel;
      logic [7:0] b;
      logic [1:0] cmd;
      int         gap;
   } item_t;

   typedef struct {
      int    sel;
      int    stall_after;
      int    restart_after;
      string bytes;
      int    exp_done;
   } vec_t;

   logic       clk = 1'b0, rst = 1'b1;
   logic [2:0] st = '0, sp = '0, tr = '1;
   logic [2:0] send_en, busy, done;
   logic [7:0] data [3];
   logic [1:0] cmd_idx [3];

   item_t sbq [$];
   int    done_cnt [3] = '{default: 0};
   int    compared = 0, failed = 0, cyc = 0, last = 0, pulses = 0;

   at_cmd_sequencer #(.NUM_CMDS(3), .MAX_LEN(8), .BYTE_GAP_CYC(G), .CMD_GAP_CYC(C), .LOOP(0)) u_one (
      .clk(clk), .rst(rst), .start(st[0]), .stop(sp[0]), .tx_ready(tr[0]),
      .data(data[0]), .send_en(send_en[0]), .busy(busy[0]), .cmd_idx(cmd_idx[0]), .done(done[0]));

   at_cmd_sequencer #(.NUM_CMDS(3), .MAX_LEN(8), .BYTE_GAP_CYC(G), .CMD_GAP_CYC(C), .LOOP(0),
      .CMD_TABLE({64'h0, 64'h3837_3635_3433_3231, 64'h0000_0000_542B_5441})) u_edge (
      .clk(clk), .rst(rst), .start(st[1]), .stop(sp[1]), .tx_ready(tr[1]),
      .data(data[1]), .send_en(send_en[1]), .busy(busy[1]), .cmd_idx(cmd_idx[1]), .done(done[1]));

   at_cmd_sequencer #(.NUM_CMDS(3), .MAX_LEN(8), .BYTE_GAP_CYC(G), .CMD_GAP_CYC(C), .LOOP(1)) u_loop (
      .clk(clk), .rst(rst), .start(st[2]), .stop(sp[2]), .tx_ready(tr[2]),
      .data(data[2]), .send_en(send_en[2]), .busy(busy[2]), .cmd_idx(cmd_idx[2]), .done(done[2]));

   always #5 clk = ~clk;

   initial forever @(posedge clk) cyc++;

   // '|' stands for CR and '~' for LF in the expected byte strings
   function automatic logic [7:0] map(input byte c);
      return c == "|" ? 8'h0D : c == "~" ? 8'h0A : 8'(c);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      item_t e;
      forever begin
         @(negedge clk);
         for (int s = 0; s < 3; s++) begin
            if (done[s]) done_cnt[s]++;
            if (send_en[s]) begin
               pulses++;
               compared++;
               if (sbq.size() == 0) begin
                  failed++;
                  $display("FAIL unexpected_pulse: dut=%0d byte=%h, expected no pulse", s, data[s]);
               end else begin
                  e = sbq.pop_front();
                  if (e.sel != s || e.b !== data[s] || e.cmd !== cmd_idx[s] || e.gap != cyc - last) begin
                     failed++;
                     $display("FAIL pulse%0d: dut=%0d byte=%h cmd=%0d gap=%0d, expected dut=%0d byte=%h cmd=%0d gap=%0d",
                              pulses, s, data[s], cmd_idx[s], cyc - last, e.sel, e.b, e.cmd, e.gap);
                  end
               end
               last = cyc;
            end
         end
      end
   end

   task automatic push_seq(input int s, input string b, input int stall_after);
      item_t it;
      int lf = 0;
      for (int i = 0; i < b.len(); i++) begin
         it.sel = s;
         it.b   = map(b[i]);
         it.cmd = 2'(lf % 3);
         it.gap = i == 0 ? 3 : (b[i-1] == "~" ? LONG : SHORT) + (i - 1 == stall_after ? 10 : 0);
         sbq.push_back(it);
         if (it.b == 8'h0A) lf++;
      end
   endtask

   task automatic kick(input int s);
      @(negedge clk);
      pulses = 0;
      last = cyc;
      st[s] = 1'b1;
      @(negedge clk);
      st[s] = 1'b0;
   endtask

   task automatic wait_drain(input string name, output int drops, input int s);
      int t = 0;
      drops = 0;
      while (sbq.size() != 0 && t < 2000) begin
         @(negedge clk);
         #1;
         if (!busy[s]) drops++;
         t++;
      end
      chk(name, sbq.size(), 0);
   endtask

   task automatic do_stall(input int s, input logic [7:0] nb);
      tr[s] = 1'b0;
      repeat (6) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk("stall_send_en", int'(send_en[s]), 0);
         chk("stall_data", int'(data[s]), int'(nb));
      end
      tr[s] = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      int s = v.sel, base;
      bit ok = 0, stalled = 0, restarted = 0;
      push_seq(s, v.bytes, v.stall_after);
      base = done_cnt[s];
      kick(s);
      for (int t = 0; t < 3000 && !ok; t++) begin
         @(negedge clk);
         #1;
         if (v.stall_after >= 0 && !stalled && pulses == v.stall_after + 1) begin
            stalled = 1;
            do_stall(s, map(v.bytes[v.stall_after + 1]));
         end
         if (v.restart_after >= 0 && !restarted && pulses == v.restart_after + 1) begin
            restarted = 1;
            st[s] = 1'b1;
            @(negedge clk);
            st[s] = 1'b0;
         end
         ok = done_cnt[s] != base;
      end
      chk("seq_done_in_time", int'(ok), 1);
      repeat (5) @(negedge clk);
      #1;
      chk("done_count", done_cnt[s] - base, v.exp_done);
      chk("busy_after_done", int'(busy[s]), 0);
      chk("scoreboard_empty", sbq.size(), 0);
      sbq.delete();
   endtask

   initial begin
      vec_t vt [4];
      int drops;
      vt[0] = '{0, -1, -1, FULL, 1};
      vt[1] = '{0, 2, -1, FULL, 1};
      vt[2] = '{1, -1, -1, "AT+T|~12345678|~|~", 1};
      vt[3] = '{0, -1, 9, FULL, 1};

      repeat (3) @(negedge clk);
      chk("rst_data", int'(data[0]), 0);
      chk("rst_send_en", int'(send_en[0]), 0);
      chk("rst_busy", int'(busy[0]), 0);
      chk("rst_cmd_idx", int'(cmd_idx[0]), 0);
      chk("rst_done", int'(done[0]), 0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run_vec(vt[i]);

      // stop during the third byte of command 1, then a clean restart
      push_seq(0, "AT+T|~AT+", -1);
      kick(0);
      wait_drain("stop_reach_byte", drops, 0);
      sp[0] = 1'b1;
      @(negedge clk);
      sp[0] = 1'b0;
      #1;
      chk("stop_busy", int'(busy[0]), 0);
      chk("stop_send_en", int'(send_en[0]), 0);
      chk("stop_cmd_idx", int'(cmd_idx[0]), 0);
      chk("stop_done", int'(done[0]), 0);
      repeat (40) @(negedge clk);
      chk("stop_pulse_count", pulses, 9);
      run_vec(vt[0]);

      // start and stop together in IDLE
      @(negedge clk);
      st[0] = 1'b1;
      sp[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      sp[0] = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("start_stop_idle_busy", int'(busy[0]), 0);

      // looping instance restarts at command 0 and never signals done
      push_seq(2, {FULL, "A"}, -1);
      kick(2);
      wait_drain("loop_restart", drops, 2);
      sp[2] = 1'b1;
      @(negedge clk);
      sp[2] = 1'b0;
      #1;
      chk("loop_busy_held", drops, 0);
      chk("loop_no_done", done_cnt[2], 0);
      chk("loop_stopped_busy", int'(busy[2]), 0);

      // asynchronous reset in WAIT_BYTE
      push_seq(0, "A", -1);
      kick(0);
      wait_drain("rst_reach_byte", drops, 0);
      @(negedge clk);
      #1;
      chk("pre_rst_busy", int'(busy[0]), 1);
      rst = 1'b1;
      #1;
      chk("async_rst_data", int'(data[0]), 0);
      chk("async_rst_busy", int'(busy[0]), 0);
      chk("async_rst_cmd_idx", int'(cmd_idx[0]), 0);
      chk("async_rst_send_en", int'(send_en[0]), 0);
      chk("async_rst_done", int'(done[0]), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      #1;
      chk("no_restart_after_rst", int'(busy[0]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end
endmodule

// File: doc/at_cmd_sequencer.md
Name: at_cmd_sequencer

Overview:
- Parametrised AT-command transmit sequencer. It sits between the pushbutton/control logic and the UART byte transmitter (data/send_en interface).
- It walks a table of NUM_CMDS ASCII commands. Each command is emitted byte by byte and terminated with CR (0x0D) and LF (0x0A).
- Pacing uses a byte gap, a transmitter-ready handshake, and a programmable inter-command gap.
- Supports one-shot or continuous-loop mode and abort.

Parameters:
NUM_CMDS, 3, number of commands in the table (>=1)
MAX_LEN, 8, maximum payload bytes per command (>=1), excluding CR/LF
CMD_TABLE, "AT+T"/"AT+SPO2"/"AT+HEART" zero-padded, flattened NUM_CMDS*MAX_LEN*8 bits; command i occupies bits [i*MAX_LEN*8 +: MAX_LEN*8]; byte j of a command sits at [j*8 +: 8]
BYTE_GAP_CYC, 100_000, minimum cycles from one send_en pulse to the next payload fetch (>=2)
CMD_GAP_CYC, 50_000_000, cycles between a command's LF and the next command's first byte (>=1)
LOOP, 0, 1 = restart at command 0 after the last command; 0 = stop and pulse done

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  begin sequence; sampled only in IDLE
stop  in  1  abort; honoured in every state
tx_ready  in  1  UART transmitter can accept a byte
data  out  8  byte to transmit; valid while send_en=1
send_en  out  1  one-cycle transmit strobe
busy  out  1  high in every state except IDLE
cmd_idx  out  clog2(NUM_CMDS) (min 1)  index of the command in progress
done  out  1  one-cycle pulse when a one-shot sequence completes

Behaviour:
- All outputs are registered. Reset values: data=0x00, send_en=0, busy=0, cmd_idx=0, done=0, state=IDLE, counters=0.
- States: IDLE, FETCH, ISSUE, WAIT_BYTE, CMD_GAP.
- IDLE:
  - start=1 -> cmd_idx=0, byte_idx=0, phase=PAYLOAD, go to FETCH.
  - start is ignored in every other state.
- FETCH (one cycle): load data.
  - PAYLOAD phase: if byte_idx==MAX_LEN or the table byte is 0x00, switch to CR phase and load 0x0D. Otherwise load the table byte.
  - CR phase loads 0x0D; LF phase loads 0x0A.
  - Next state ISSUE.
- ISSUE: hold until tx_ready=1, then:
  - send_en=1 for exactly one cycle;
  - gap counter = BYTE_GAP_CYC-1;
  - go to WAIT_BYTE.
  - While tx_ready=0, data stays stable and send_en=0.
- WAIT_BYTE: decrement the counter; on 0:
  - byte was LF -> load CMD_GAP_CYC-1 and go to CMD_GAP;
  - byte was CR -> phase=LF, go to FETCH;
  - otherwise byte_idx+1, go to FETCH.
- CMD_GAP: decrement the counter; on 0:
  - cmd_idx<NUM_CMDS-1 -> cmd_idx+1, byte_idx=0, phase=PAYLOAD, go to FETCH;
  - last command with LOOP=1 -> cmd_idx=0, go to FETCH;
  - last command with LOOP=0 -> done=1 for one cycle, go to IDLE.
- Timing with tx_ready held high:
  - start sampled at edge k -> send_en high between edges k+2 and k+3.
  - Pulse-to-pulse spacing within a command is BYTE_GAP_CYC+2 cycles.
  - LF pulse to the next command's first pulse is BYTE_GAP_CYC+CMD_GAP_CYC+2 cycles.
- Empty command (first byte 0x00) emits only CR, LF.
- A command with no 0x00 in its slot emits all MAX_LEN bytes, then CR, LF.
- stop=1 in any state:
  - next edge -> IDLE, send_en=0, busy=0, done=0, cmd_idx=0;
  - a byte already strobed is not recalled.
  - start and stop both high in IDLE: stop wins, remain IDLE.
- Counters must be wide enough for max(BYTE_GAP_CYC, CMD_GAP_CYC). No wrap-around is permitted.
- rst asserted mid-command forces the reset values immediately (asynchronously). Sequencing restarts only on a new start.

Test Plan:
- Bench parameters: NUM_CMDS=3, MAX_LEN=8, BYTE_GAP_CYC=4, CMD_GAP_CYC=20, LOOP=0, default table.
1. One-shot, tx_ready=1, start pulse -> exactly 25 send_en pulses with bytes "AT+T",0D,0A,"AT+SPO2",0D,0A,"AT+HEART",0D,0A. Spacing is 6 cycles within a command and 26 cycles at each command boundary. done pulses once, busy falls, cmd_idx shows 0,1,2.
2. Handshake: drop tx_ready for 10 cycles while in ISSUE -> no send_en during the stall, data stable. Strobe occurs the cycle after tx_ready rises; the byte sequence is unchanged.
3. Boundary table: command 1 = 8 bytes with no 0x00, command 2 = all zero -> 8 payload bytes + 0D 0A, then only 0D 0A for command 2.
4. LOOP=1 -> after the third LF and a 20-cycle gap, "A" of command 0 is strobed again. done never pulses; busy stays 1.
5. stop asserted during command 1's third byte -> IDLE next edge, no further send_en, cmd_idx=0. A following start restarts at "A" of command 0.
6. rst pulsed mid-WAIT_BYTE -> outputs at reset values asynchronously. start asserted during busy (no reset) -> ignored; the sequence is not restarted.
